// File: rtl/bus_timer_if.sv
// Bus port bundle for the timer responder.
// Handshake: a request is cyc_i & stb_i while ack_o is low; the responder
// raises ack_o for exactly one cycle, one cycle after it sees the request,
// and dat_o carries read data only while ack_o is high (zero otherwise).
interface bus_timer_if;
    logic        cyc_i;
    logic        stb_i;
    logic        we_i;
    logic [3:0]  sel_i;
    logic [2:0]  adr_i;
    logic [31:0] dat_i;
    logic [31:0] dat_o;
    logic        ack_o;

    modport master (
        output cyc_i, stb_i, we_i, sel_i, adr_i, dat_i,
        input  dat_o, ack_o
    );

    modport slave (
        input  cyc_i, stb_i, we_i, sel_i, adr_i, dat_i,
        output dat_o, ack_o
    );
endinterface

// File: rtl/bus_timer.sv
// Memory-mapped 32-bit timer: prescaled up-counter, compare register,
// sticky match flag and registered level interrupt.
module bus_timer #(
    parameter int          PRESCALE_W  = 16,
    parameter logic [31:0] COMPARE_RST = 32'hffffffff
) (
    input  logic       clk_i,
    input  logic       rst_i,
    bus_timer_if.slave bus,
    output logic       interrupt_o
);

    localparam logic [2:0] ADR_CTRL     = 3'd0;
    localparam logic [2:0] ADR_STATUS   = 3'd1;
    localparam logic [2:0] ADR_COUNT    = 3'd2;
    localparam logic [2:0] ADR_COMPARE  = 3'd3;
    localparam logic [2:0] ADR_PRESCALE = 3'd4;

    // CTRL bits: [0] EN, [1] IE, [2] AR
    logic [2:0]            ctrl_q,     ctrl_d;
    logic                  match_q,    match_d;
    logic [31:0]           count_q,    count_d;
    logic [31:0]           compare_q,  compare_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic [PRESCALE_W-1:0] pcnt_q,     pcnt_d;
    logic                  ack_q,      ack_d;
    logic [31:0]           dat_q,      dat_d;
    logic                  irq_q,      irq_d;

    logic        req;
    logic        wr_req;
    logic        tick;
    logic        hit;
    logic [31:0] prescale_ext;
    logic [31:0] rdata;

    // The ack cycle masks the bus so a held request is acked every other cycle.
    assign req    = bus.cyc_i & bus.stb_i & ~ack_q;
    assign wr_req = req & bus.we_i;

    // Tick uses the registered CTRL, so a CTRL write affects ticks one cycle later.
    assign tick = ctrl_q[0] && (pcnt_q == prescale_q);
    assign hit  = tick && (count_q == compare_q);

    // Zero-extend the prescale divider to bus width for reads.
    always_comb begin
        prescale_ext = '0;
        prescale_ext[PRESCALE_W-1:0] = prescale_q;
    end

    // Read mux over the current register values.
    always_comb begin
        rdata = '0;
        case (bus.adr_i)
            ADR_CTRL:     rdata = {29'd0, ctrl_q};
            ADR_STATUS:   rdata = {31'd0, match_q};
            ADR_COUNT:    rdata = count_q;
            ADR_COMPARE:  rdata = compare_q;
            ADR_PRESCALE: rdata = prescale_ext;
            default:      rdata = '0;
        endcase
    end

    // Next-state: tick behaviour first, bus writes override, match set last.
    always_comb begin
        ctrl_d     = ctrl_q;
        match_d    = match_q;
        count_d    = count_q;
        compare_d  = compare_q;
        prescale_d = prescale_q;
        pcnt_d     = pcnt_q;

        if (ctrl_q[0]) begin
            pcnt_d = tick ? '0 : pcnt_q + PRESCALE_W'(1);
        end

        if (tick) begin
            count_d = (hit && ctrl_q[2]) ? 32'd0 : count_q + 32'd1;
        end

        if (wr_req) begin
            case (bus.adr_i)
                ADR_CTRL: begin
                    if (bus.sel_i[0]) ctrl_d = bus.dat_i[2:0];
                end
                ADR_STATUS: begin
                    if (bus.sel_i[0] && bus.dat_i[0]) match_d = 1'b0;
                end
                ADR_COUNT: begin
                    // Unselected lanes keep the tick-updated value.
                    for (int b = 0; b < 32; b++) begin
                        if (bus.sel_i[b/8]) count_d[b] = bus.dat_i[b];
                    end
                end
                ADR_COMPARE: begin
                    for (int b = 0; b < 32; b++) begin
                        if (bus.sel_i[b/8]) compare_d[b] = bus.dat_i[b];
                    end
                end
                ADR_PRESCALE: begin
                    for (int b = 0; b < PRESCALE_W; b++) begin
                        if (bus.sel_i[b/8]) prescale_d[b] = bus.dat_i[b];
                    end
                    if (|bus.sel_i) pcnt_d = '0;
                end
                default: ;
            endcase
        end

        // A match in the same cycle as a W1C clear wins.
        if (hit) match_d = 1'b1;

        ack_d = req;
        dat_d = (req && !bus.we_i) ? rdata : 32'd0;
        irq_d = match_q & ctrl_q[1];
    end

    // State registers with synchronous reset; reset also discards an in-flight write.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ctrl_q     <= '0;
            match_q    <= 1'b0;
            count_q    <= '0;
            compare_q  <= COMPARE_RST;
            prescale_q <= '0;
            pcnt_q     <= '0;
            ack_q      <= 1'b0;
            dat_q      <= '0;
            irq_q      <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            match_q    <= match_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            prescale_q <= prescale_d;
            pcnt_q     <= pcnt_d;
            ack_q      <= ack_d;
            dat_q      <= dat_d;
            irq_q      <= irq_d;
        end
    end

    assign bus.ack_o   = ack_q;
    assign bus.dat_o   = dat_q;
    assign interrupt_o = irq_q;

endmodule

// File: tb/tb_bus_timer.sv
// Directed bench for bus_timer: register map, compare/interrupt timing,
// auto-reload, byte lanes, same-cycle priorities and bus protocol.
module tb_bus_timer;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic irq;
    int   checks   = 0;
    int   failures = 0;
    logic [31:0] exp_q[$];

    bus_timer_if bus();

    bus_timer #(
        .PRESCALE_W (16),
        .COMPARE_RST(32'hffffffff)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .bus        (bus),
        .interrupt_o(irq)
    );

    // Clock: 10 ns period.
    always #5 clk = ~clk;

    // Advance n cycles; samples land 1 ns after the rising edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_idle();
        bus.cyc_i = 1'b0;
        bus.stb_i = 1'b0;
        bus.we_i  = 1'b0;
        bus.sel_i = 4'h0;
        bus.adr_i = 3'd0;
        bus.dat_i = 32'd0;
    endtask

    // One transfer; lat = cycles from issue to ack, 0 if no ack within 4 cycles.
    task automatic bus_xfer(input logic we, input logic [2:0] adr, input logic [31:0] wdat,
                            input logic [3:0] sel, output logic [31:0] rdat, output int lat);
        bus.cyc_i = 1'b1;
        bus.stb_i = 1'b1;
        bus.we_i  = we;
        bus.adr_i = adr;
        bus.dat_i = wdat;
        bus.sel_i = sel;
        lat  = 0;
        rdat = 32'd0;
        for (int i = 1; i <= 4; i++) begin
            step(1);
            if (bus.ack_o) begin
                lat  = i;
                rdat = bus.dat_o;
                break;
            end
        end
        bus_idle();
    endtask

    task automatic bus_write(input logic [2:0] adr, input logic [31:0] wdat, input logic [3:0] sel);
        logic [31:0] d;
        int lat;
        bus_xfer(1'b1, adr, wdat, sel, d, lat);
        checks++;
        if (lat == 0) begin
            failures++;
            $display("FAIL write_ack adr=%0d: got no ack, required ack within 4 cycles", adr);
        end
    endtask

    task automatic bus_read(input logic [2:0] adr, output logic [31:0] rdat);
        int lat;
        bus_xfer(1'b0, adr, 32'd0, 4'hf, rdat, lat);
        checks++;
        if (lat == 0) begin
            failures++;
            $display("FAIL read_ack adr=%0d: got no ack, required ack within 4 cycles", adr);
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        int lat;
        rst = 1'b1;
        step(2);
        checks++;
        if (bus.ack_o !== 1'b0 || bus.dat_o !== 32'd0 || irq !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: ack=%b dat=%h irq=%b, required 0/0/0", bus.ack_o, bus.dat_o, irq);
        end
        rst = 1'b0;
        step(1);
        bus_xfer(1'b0, 3'd3, 32'd0, 4'hf, d, lat);
        checks++;
        if (lat !== 1) begin
            failures++;
            $display("FAIL read_latency: got %0d, required 1", lat);
        end
        checks++;
        if (d !== 32'hffffffff) begin
            failures++;
            $display("FAIL reset_compare: got %h, required ffffffff", d);
        end
        for (int a = 0; a < 3; a++) begin
            bus_read(3'(a), d);
            checks++;
            if (d !== 32'd0) begin
                failures++;
                $display("FAIL reset_reg%0d: got %h, required 00000000", a, d);
            end
        end
    endtask

    task automatic test_compare_irq();
        logic [31:0] d;
        bus_write(3'd3, 32'd5, 4'hf);
        bus_write(3'd4, 32'd0, 4'hf);
        bus_write(3'd0, 32'd3, 4'hf);
        // Count value c is present in the cycle c after this ack; c=5 ticks
        // at ack+5, MATCH at ack+6, interrupt at ack+7.
        step(6);
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL irq_early: got %b, required 0", irq);
        end
        step(1);
        checks++;
        if (irq !== 1'b1) begin
            failures++;
            $display("FAIL irq_rise: got %b, required 1", irq);
        end
        bus_read(3'd2, d);
        checks++;
        if (d !== 32'd7) begin
            failures++;
            $display("FAIL count_after_match: got %0d, required 7", d);
        end
        bus_read(3'd1, d);
        checks++;
        if (d !== 32'd1) begin
            failures++;
            $display("FAIL match_sticky: got %h, required 1", d);
        end
        bus_write(3'd1, 32'd1, 4'hf);
        checks++;
        if (irq !== 1'b1) begin
            failures++;
            $display("FAIL irq_hold_at_clear: got %b, required 1", irq);
        end
        step(1);
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL irq_fall: got %b, required 0", irq);
        end
        bus_write(3'd0, 32'd0, 4'hf);
    endtask

    task automatic test_auto_reload();
        logic [31:0] d;
        int acks;
        bus_write(3'd2, 32'd0, 4'hf);
        bus_write(3'd1, 32'd1, 4'hf);
        bus_write(3'd3, 32'd3, 4'hf);
        bus_write(3'd4, 32'd2, 4'hf);
        bus_write(3'd0, 32'd5, 4'hf);
        // Count at x cycles after this ack is (x/3) mod 4; a held read
        // samples odd x.
        exp_q.delete();
        for (int x = 1; x <= 23; x += 2) exp_q.push_back(32'((x / 3) % 4));
        bus.cyc_i = 1'b1;
        bus.stb_i = 1'b1;
        bus.we_i  = 1'b0;
        bus.adr_i = 3'd2;
        bus.sel_i = 4'hf;
        acks = 0;
        for (int i = 1; i <= 24; i++) begin
            step(1);
            if (bus.ack_o) begin
                acks++;
                if (exp_q.size() > 0) begin
                    d = exp_q.pop_front();
                    checks++;
                    if (bus.dat_o !== d) begin
                        failures++;
                        $display("FAIL ar_count[%0d]: got %0d, required %0d", acks, bus.dat_o, d);
                    end
                end
            end
        end
        bus_idle();
        checks++;
        if (acks !== 12) begin
            failures++;
            $display("FAIL ar_ack_count: got %0d, required 12", acks);
        end
        bus_read(3'd1, d);
        checks++;
        if (d !== 32'd1 || irq !== 1'b0) begin
            failures++;
            $display("FAIL ar_match_no_ie: status=%h irq=%b, required 1/0", d, irq);
        end
        bus_write(3'd0, 32'd0, 4'hf);
        bus_write(3'd1, 32'd1, 4'hf);
    endtask

    task automatic test_byte_lanes();
        logic [31:0] d;
        bus_write(3'd2, 32'h11223344, 4'hf);
        bus_write(3'd2, 32'haabbccdd, 4'b0101);
        bus_read(3'd2, d);
        checks++;
        if (d !== 32'h11bb33dd) begin
            failures++;
            $display("FAIL byte_lane_count: got %h, required 11bb33dd", d);
        end
        bus_write(3'd2, 32'hffffffff, 4'b0000);
        bus_read(3'd2, d);
        checks++;
        if (d !== 32'h11bb33dd) begin
            failures++;
            $display("FAIL sel_zero_write: got %h, required 11bb33dd", d);
        end
        bus_write(3'd5, 32'hdeadbeef, 4'hf);
        bus_read(3'd5, d);
        checks++;
        if (d !== 32'd0) begin
            failures++;
            $display("FAIL unmapped_read: got %h, required 00000000", d);
        end
        bus_write(3'd4, 32'hffffffff, 4'hf);
        bus_read(3'd4, d);
        checks++;
        if (d !== 32'h0000ffff) begin
            failures++;
            $display("FAIL prescale_width: got %h, required 0000ffff", d);
        end
        bus_write(3'd0, 32'hffffffff, 4'b1110);
        bus_read(3'd0, d);
        checks++;
        if (d !== 32'd0) begin
            failures++;
            $display("FAIL ctrl_lane_mask: got %h, required 00000000", d);
        end
        bus_write(3'd4, 32'd0, 4'hf);
    endtask

    task automatic test_simultaneous();
        logic [31:0] d;
        bus_write(3'd3, 32'd10, 4'hf);
        bus_write(3'd2, 32'd8, 4'hf);
        bus_write(3'd1, 32'd1, 4'hf);
        bus_write(3'd0, 32'd1, 4'hf);
        // Ticks every cycle: count 8 now, 10 two cycles later (match tick).
        step(2);
        bus_write(3'd1, 32'd1, 4'hf);
        bus_write(3'd0, 32'd0, 4'hf);
        bus_read(3'd1, d);
        checks++;
        if (d !== 32'd1) begin
            failures++;
            $display("FAIL match_beats_w1c: got %h, required 1", d);
        end
        bus_write(3'd4, 32'd5, 4'hf);
        bus_write(3'd2, 32'd0, 4'hf);
        bus_write(3'd0, 32'd1, 4'hf);
        // First tick lands 5 cycles after the enabling ack.
        step(5);
        bus_write(3'd2, 32'd100, 4'hf);
        bus_read(3'd2, d);
        checks++;
        if (d !== 32'd100) begin
            failures++;
            $display("FAIL write_beats_tick: got %0d, required 100", d);
        end
        bus_write(3'd0, 32'd0, 4'hf);
    endtask

    task automatic test_protocol();
        logic [31:0] d;
        logic exp_ack;
        step(1);
        bus.cyc_i = 1'b1;
        bus.stb_i = 1'b1;
        bus.we_i  = 1'b0;
        bus.adr_i = 3'd3;
        bus.sel_i = 4'hf;
        for (int i = 0; i < 6; i++) begin
            exp_ack = (i % 2) == 1;
            checks++;
            if (bus.ack_o !== exp_ack || bus.dat_o !== (exp_ack ? 32'd10 : 32'd0)) begin
                failures++;
                $display("FAIL held_request[%0d]: ack=%b dat=%h, required %b/%h",
                         i, bus.ack_o, bus.dat_o, exp_ack, exp_ack ? 32'd10 : 32'd0);
            end
            step(1);
        end
        bus_idle();
        step(1);
        // Strobe without cycle: no request.
        bus.stb_i = 1'b1;
        bus.we_i  = 1'b1;
        bus.adr_i = 3'd3;
        bus.sel_i = 4'hf;
        bus.dat_i = 32'h77;
        step(1);
        checks++;
        if (bus.ack_o !== 1'b0) begin
            failures++;
            $display("FAIL no_cyc_ack: got %b, required 0", bus.ack_o);
        end
        bus_idle();
        bus_read(3'd3, d);
        checks++;
        if (d !== 32'd10) begin
            failures++;
            $display("FAIL no_cyc_effect: got %h, required 0000000a", d);
        end
        step(1);
        // Reset in the request cycle discards the write.
        bus.cyc_i = 1'b1;
        bus.stb_i = 1'b1;
        bus.we_i  = 1'b1;
        bus.adr_i = 3'd3;
        bus.sel_i = 4'hf;
        bus.dat_i = 32'h12345678;
        rst = 1'b1;
        step(1);
        checks++;
        if (bus.ack_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_ack: got %b, required 0", bus.ack_o);
        end
        rst = 1'b0;
        bus_idle();
        step(1);
        bus_read(3'd3, d);
        checks++;
        if (d !== 32'hffffffff) begin
            failures++;
            $display("FAIL reset_discard: got %h, required ffffffff", d);
        end
    endtask

    initial begin
        bus_idle();
        step(1);
        test_reset();
        test_compare_irq();
        test_auto_reload();
        test_byte_lanes();
        test_simultaneous();
        test_protocol();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
